// File: rtl/multiplier32.sv
`default_nettype none
// ============================================================================
//  Module   : multiplier32
//  Purpose  : Sequential radix-2 shift-add integer multiplier,
//             WIDTH x WIDTH -> 2*WIDTH, signed (two's complement) or unsigned.
//             One partial product is retired per clock. The block presents
//             the same idle/busy contract as the sequential divider it sits
//             beside.
//
//  Ports    : clk           rising-edge clock
//             async_rst_n   asynchronous active-low reset (sync deassertion
//                           is the responsibility of the reset generator)
//             valid         operand-valid request; accepted when ready=1
//             MULTIPLICAND  operand A, sampled only on acceptance
//             MULTIPLIER    operand B, sampled only on acceptance
//             P             2*WIDTH product, stable while ready=1
//             ready         1 = idle and P holds the last result (or 0)
//             done          one-cycle pulse when a run completes
//
//  Revision : 1.0  initial release
// ============================================================================
module multiplier32 #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               async_rst_n,
   input  logic               valid,
   input  logic [WIDTH-1:0]   MULTIPLICAND,
   input  logic [WIDTH-1:0]   MULTIPLIER,
   output logic [2*WIDTH-1:0] P,
   output logic               ready,
   output logic               done
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   // The counter must be able to hold WIDTH itself (value after the last step).
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [CW-1:0]      C_CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]      C_CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   C_ONE_W    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] C_ONE_P    = (2*WIDTH)'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [0:0]         state_q,  state_d;
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic [WIDTH-1:0]   mcand_q,  mcand_d;   // |A|
   logic [WIDTH-1:0]   mplier_q, mplier_d;  // |B|, consumed LSB first
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic               neg_q,    neg_d;
   logic [2*WIDTH-1:0] p_q,      p_d;
   logic               done_q,   done_d;

   // ------------------------------------------------------------------------
   // Operand conditioning
   // ------------------------------------------------------------------------
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   generate
      if (SIGNED) begin : g_signed_ops
         assign sign_a = MULTIPLICAND[WIDTH-1];
         assign sign_b = MULTIPLIER[WIDTH-1];
      end else begin : g_unsigned_ops
         assign sign_a = 1'b0;
         assign sign_b = 1'b0;
      end
   endgenerate

   // Magnitudes are held as WIDTH-bit unsigned values, so the most negative
   // operand -2^(WIDTH-1) negates to 2^(WIDTH-1) without overflow.
   assign mag_a = sign_a ? (~MULTIPLICAND + C_ONE_W) : MULTIPLICAND;
   assign mag_b = sign_b ? (~MULTIPLIER   + C_ONE_W) : MULTIPLIER;

   // ------------------------------------------------------------------------
   // One shift-add step
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum_hi;     // upper half plus carry out
   logic [2*WIDTH-1:0] step_acc;
   logic               accept;
   logic               busy;
   logic               last_step;

   assign addend   = mplier_q[0] ? mcand_q : '0;
   assign sum_hi   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   // The carry out of the add becomes the new MSB; the lowest accumulator bit
   // is shifted out as the product bit it already represents.
   assign step_acc = {sum_hi, acc_q[WIDTH-1:1]};

   assign accept    = (state_q == S_IDLE) && valid;
   assign busy      = (state_q == S_BUSY);
   assign last_step = busy && (cnt_q == C_CNT_LAST);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (valid)     state_d = S_BUSY;
         S_BUSY:  if (last_step) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs (all derived from registers only)
   // ------------------------------------------------------------------------
   always_comb begin
      ready = (state_q == S_IDLE);
      done  = done_q;
      P     = p_q;
   end

   // ------------------------------------------------------------------------
   // Datapath next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      p_d      = p_q;
      done_d   = 1'b0;

      if (accept) begin
         mcand_d  = mag_a;
         mplier_d = mag_b;
         neg_d    = sign_a ^ sign_b;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (busy) begin
         mplier_d = mplier_q >> 1;
         acc_d    = step_acc;
         cnt_d    = cnt_q + C_CNT_ONE;
         if (last_step) begin
            // A zero magnitude negates back to zero, so no -0 can appear.
            p_d    = neg_q ? (~step_acc + C_ONE_P) : step_acc;
            done_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         p_q      <= '0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         p_q      <= p_d;
         done_q   <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/multiplier32.md
Name: multiplier32

Overview:
- Sequential signed/unsigned integer multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Radix-2 shift-add: one partial product per cycle.
- Shares the valid/ready operand handshake of the arithmetic unit cluster; it is the companion of the sequential divider.
- Sits beside the divider behind the same issue logic, so both blocks present an identical idle/busy contract.

Parameters:
- WIDTH, 32, operand width in bits (>=2); iteration count equals WIDTH.
- SIGNED, 1, 1 = two's-complement operands and product; 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock.
- async_rst_n  input  1  asynchronous, active-low reset.
- valid  input  1  operand-valid request.
- MULTIPLICAND  input  WIDTH  operand A; sampled only on acceptance.
- MULTIPLIER  input  WIDTH  operand B; sampled only on acceptance.
- P  output  2*WIDTH  product; held stable while ready=1.
- ready  output  1  1 = idle, and the result of the last operation (if any) is valid on P.
- done  output  1  one-cycle pulse in the first cycle ready returns high after a run.

Behaviour:
- Reset (async_rst_n=0, immediate, no clock needed):
  - ready=1, done=0, P=0.
  - Iteration counter, magnitudes and sign flag cleared.
  - Deassertion is synchronous to clk; the first accept is possible on the first rising edge after deassertion.
- States: IDLE (ready=1) and BUSY (ready=0).
- Acceptance: on a rising edge with valid=1 and ready=1.
  - Latch |A| and |B| as WIDTH-bit unsigned magnitudes.
  - In SIGNED=1 mode, take the magnitude only when the operand MSB is 1 (two's-complement negate). -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1) with no overflow.
  - Latch neg = A[MSB]^B[MSB] (neg=0 when SIGNED=0).
  - Clear the 2*WIDTH accumulator and the counter; go to BUSY.
  - P keeps its old value until completion.
- BUSY, each edge:
  - If the multiplier-magnitude LSB = 1, add the multiplicand magnitude into the accumulator upper half.
  - Shift accumulator and multiplier-magnitude right by 1; the carry out of the add enters the accumulator MSB.
  - counter += 1.
- Completion: on the edge where counter reaches WIDTH (the WIDTH-th BUSY edge):
  - P <= neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits.
  - ready <= 1, done <= 1 for exactly one cycle.
- Latency: operands accepted at edge k -> P valid and ready=1 after edge k+WIDTH (k+32 by default).
- Throughput: the next accept is at edge k+WIDTH+1 at the earliest, i.e. one operation per WIDTH+1 cycles.
- valid while BUSY: ignored. Operand ports are not sampled and no queueing occurs.
- valid held high continuously: a new operation is accepted on the first edge with ready=1. done and acceptance may coincide in that cycle.
- Zero operand: still runs the full WIDTH cycles; P=0 (never -0 artefacts).
- Reset mid-operation: the run is aborted and the block returns to the reset state above. No done pulse; P=0.
- No combinational path from valid or the operands to ready, done or P. All outputs are registered.

Test Plan:
- Reset, then A=7, B=-3 (0xFFFFFFFD), SIGNED=1 -> ready low for 32 cycles; after edge k+32, P=0xFFFFFFFF_FFFFFFEB (-21), done pulses once.
- A=B=0x80000000, SIGNED=1 -> P=0x40000000_00000000. Also A=B=0xFFFFFFFF -> P=0x00000000_00000001.
- SIGNED=0 build, A=B=0xFFFFFFFF -> P=0xFFFFFFFE_00000001. Also A=0x12345678, B=0 -> P=0 after 32 cycles.
- Busy interference: accept 5*6; at cycle 10 drive valid=1 with A=B=9 -> ignored; P=30 at completion; ready/done timing unchanged.
- Back-to-back: valid held high with 3*4, then 100*-1 -> P=12 with done after edge k+32; second op accepted at edge k+33; P=-100 after edge k+65.
- Drop async_rst_n at BUSY cycle 15 (between edges) -> ready=1, P=0, done=0 immediately. After release, 2*2 -> P=4 with normal latency.
